// File: rtl/stash_scan_table_multi_if.sv
// Scan-port bundle between the stash core, the scan table and the eviction logic.
// With SCAN_PADDR_MATCH_EN defined it also carries the InMatchPAddr/InMatchValid lookup pair.
interface stash_scan_table_multi_if #(
    parameter int ORAML        = 32,
    parameter int ORAMU        = 32,
    parameter int StashEAWidth = 8
);
    localparam int LW = $clog2(ORAML + 1);

    logic                    InStart;
    logic [ORAML-1:0]        CurrentLeaf;
    logic [ORAML-1:0]        InLeaf;
    logic [ORAMU-1:0]        InPAddr;
    logic [StashEAWidth-1:0] InSAddr;
    logic                    InValid;
    logic [StashEAWidth-1:0] OutSAddr;
    logic [LW-1:0]           OutLevel;
    logic                    OutAccepted;
    logic                    OutValid;
    logic                    OutPathFull;
    logic                    OutPAddrHit;
`ifdef SCAN_PADDR_MATCH_EN
    logic [ORAMU-1:0]        InMatchPAddr;
    logic                    InMatchValid;
`endif

    modport master (
        output InStart, CurrentLeaf, InLeaf, InPAddr, InSAddr, InValid,
`ifdef SCAN_PADDR_MATCH_EN
        output InMatchPAddr, InMatchValid,
`endif
        input  OutSAddr, OutLevel, OutAccepted, OutValid, OutPathFull, OutPAddrHit
    );

    modport slave (
        input  InStart, CurrentLeaf, InLeaf, InPAddr, InSAddr, InValid,
`ifdef SCAN_PADDR_MATCH_EN
        input  InMatchPAddr, InMatchValid,
`endif
        output OutSAddr, OutLevel, OutAccepted, OutValid, OutPathFull, OutPAddrHit
    );
endinterface

// File: rtl/stash_scan_table_multi.sv
// Two-stage greedy deepest-first placement of scanned stash entries onto the current path.
// Optional feature macro: SCAN_PADDR_MATCH_EN (PAddr match strobe aligned with OutValid).
module stash_scan_table_multi #(
    parameter int ORAML        = 32,
    parameter int ORAMU        = 32,
    parameter int Z            = 4,
    parameter int StashEAWidth = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    stash_scan_table_multi_if.slave scan
);
    localparam int LW = $clog2(ORAML + 1);
    localparam int CW = $clog2(Z + 1);

    function automatic logic [LW-1:0] lzc(input logic [ORAML-1:0] x);
        logic [LW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = ORAML - 1; i >= 0; i--) begin
            if (!hit) begin
                if (x[i]) hit = 1'b1;
                else      n   = n + LW'(1);
            end
        end
        return n;
    endfunction

    logic [ORAML-1:0]        leaf_q;
    logic [ORAML-1:0]        cmp_leaf;
    logic [LW-1:0]           s1_d_d;
    logic                    s1_valid_q;
    logic [LW-1:0]           s1_d_q;
    logic [StashEAWidth-1:0] s1_saddr_q;

    logic [CW-1:0]           cnt_q [ORAML+1];
    logic [CW-1:0]           cnt_d [ORAML+1];
    logic                    full_q, full_d;
    logic                    found;
    logic [LW-1:0]           pick;
    logic [LW-1:0]           level_d;

    logic                    out_valid_q;
    logic                    out_accepted_q;
    logic [LW-1:0]           out_level_q;
    logic [StashEAWidth-1:0] out_saddr_q;

    // An entry arriving with InStart is judged against the new leaf.
    assign cmp_leaf = scan.InStart ? scan.CurrentLeaf : leaf_q;
    assign s1_d_d   = lzc(scan.InLeaf ^ cmp_leaf);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            leaf_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_d_q     <= '0;
            s1_saddr_q <= '0;
        end else begin
            if (scan.InStart) leaf_q <= scan.CurrentLeaf;
            s1_valid_q <= scan.InValid;
            s1_d_q     <= s1_d_d;
            s1_saddr_q <= scan.InSAddr;
        end
    end

    always_comb begin
        found  = 1'b0;
        pick   = '0;
        full_d = 1'b1;
        for (int l = 0; l <= ORAML; l++) begin
            if ((LW'(l) <= s1_d_q) && (cnt_q[l] < CW'(Z))) begin
                found = 1'b1;
                pick  = LW'(l);
            end
        end
        level_d = (s1_valid_q && found) ? pick : '0;
        for (int l = 0; l <= ORAML; l++) begin
            cnt_d[l] = cnt_q[l];
            if (s1_valid_q && found && (pick == LW'(l))) cnt_d[l] = cnt_q[l] + CW'(1);
            if (cnt_d[l] != CW'(Z)) full_d = 1'b0;
        end
    end

    // InStart drops whatever sits in stage 1 and clears the path occupancy.
    always_ff @(posedge Clock) begin
        if (Reset || scan.InStart) begin
            for (int l = 0; l <= ORAML; l++) cnt_q[l] <= '0;
            full_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_accepted_q <= 1'b0;
            out_level_q    <= '0;
            out_saddr_q    <= '0;
        end else begin
            for (int l = 0; l <= ORAML; l++) cnt_q[l] <= cnt_d[l];
            full_q         <= full_d;
            out_valid_q    <= s1_valid_q;
            out_accepted_q <= s1_valid_q & found;
            out_level_q    <= level_d;
            out_saddr_q    <= s1_saddr_q;
        end
    end

    assign scan.OutValid    = out_valid_q;
    assign scan.OutAccepted = out_accepted_q;
    assign scan.OutLevel    = out_level_q;
    assign scan.OutSAddr    = out_saddr_q;
    assign scan.OutPathFull = full_q;

`ifdef SCAN_PADDR_MATCH_EN
    logic [ORAMU-1:0] s1_paddr_q;
    logic             hit_q;

    always_ff @(posedge Clock) begin
        if (Reset) s1_paddr_q <= '0;
        else       s1_paddr_q <= scan.InPAddr;
    end

    always_ff @(posedge Clock) begin
        if (Reset || scan.InStart) hit_q <= 1'b0;
        else hit_q <= s1_valid_q & scan.InMatchValid & (s1_paddr_q == scan.InMatchPAddr);
    end

    assign scan.OutPAddrHit = hit_q;
`else
    logic unused_paddr;
    assign unused_paddr     = ^scan.InPAddr;
    assign scan.OutPAddrHit = 1'b0;
`endif
endmodule
